sdram_wb_arbiter: RTL and testbench

Two-master Wishbone arbiter that shares the single SDRAM Wishbone port between the USB FIFO ingest path (master 0, writes image/weight words arriving from the FX2 FIFO) and the ConvNet compute engine (master 1, reads operands and writes results). It grants the bus per bus cycle: a grant is held while the granted master keeps `cyc` high. A watchdog reclaims the bus from a master whose cycle never completes. Sits between the masters and the SDRAM controller, all in the `CLKOUT` domain.

---
 rtl/sdram_wb_pkg.sv | 25 ++
 rtl/arb_watchdog.sv | 40 ++++
 rtl/sdram_wb_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_sdram_wb_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_wb_pkg.sv
// Shared definitions for the SDRAM Wishbone arbiter.
// Contents:
//   - arb_state_t : arbiter FSM state encoding
//   - SDRAM_AW / SDRAM_DW : default address / data widths
//   - WB_*_IDLE   : values driven on Wishbone signals that nobody owns
package sdram_wb_pkg;

    localparam int SDRAM_AW = 32;
    localparam int SDRAM_DW = 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GNT0  = 2'd1,
        S_GNT1  = 2'd2,
        S_BLOCK = 2'd3
    } arb_state_t;

    localparam logic       WB_CYC_IDLE   = 1'b0;
    localparam logic       WB_STB_IDLE   = 1'b0;
    localparam logic       WB_WE_IDLE    = 1'b0;
    localparam logic       WB_ACK_IDLE   = 1'b0;
    localparam logic       WB_STALL_IDLE = 1'b1;
    localparam logic [3:0] WB_SEL_IDLE   = 4'h0;

endpackage

// File: rtl/arb_watchdog.sv
// Bus-ownership watchdog for sdram_wb_arbiter.
// Counts cycles while a grant is active and flags when the owner has gone
// TIMEOUT-1 cycles without an acknowledge. The counter saturates and never wraps.
// Ports:
//   i_clk      : clock (CLKOUT domain)
//   i_rst_n    : asynchronous active-low reset
//   i_clr      : clear counter (no owner, or slave ack)
//   i_en       : count enable (a master owns the bus)
//   o_expired  : count has reached TIMEOUT-1
module arb_watchdog
    import sdram_wb_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int            CW      = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] CNT_LIM = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expired = (r_cnt == CNT_LIM);

endmodule

// File: rtl/sdram_wb_arbiter.sv
// Two-master Wishbone arbiter in front of the single SDRAM slave port.
// Master 0 = USB FIFO ingest, master 1 = ConvNet engine. The bus is granted
// per Wishbone cycle and held while the owner keeps cyc high; a watchdog
// reclaims the bus from an owner that goes TIMEOUT-1 cycles without an ack.
// Build option:
//   SDRAM_ARB_RR_EN defined   -> round-robin tie-break (pointer starts at "last = 1")
//   SDRAM_ARB_RR_EN undefined -> fixed priority, master 0 wins ties
// Ports:
//   CLKOUT, rst_n                      : clock, async active-low reset
//   mX_cyc_i/stb_i/we_i/sel_i/addr_i/data_i : master X requests
//   mX_data_o/ack_o/stall_o            : responses to master X
//   cyc_i/stb_i/we_i/sel_i/addr_i/data_i    : requests to the SDRAM slave
//   data_o/stall_o/sdram_ack           : responses from the SDRAM slave
//   grant                              : one-hot current owner, 0 when idle
//   timeout_o                          : one-cycle pulse on watchdog release
module sdram_wb_arbiter
    import sdram_wb_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int AW      = SDRAM_AW,
    parameter int DW      = SDRAM_DW
) (
    input  logic          CLKOUT,
    input  logic          rst_n,
    input  logic          m0_cyc_i,
    input  logic          m0_stb_i,
    input  logic          m0_we_i,
    input  logic [3:0]    m0_sel_i,
    input  logic [AW-1:0] m0_addr_i,
    input  logic [DW-1:0] m0_data_i,
    output logic [DW-1:0] m0_data_o,
    output logic          m0_ack_o,
    output logic          m0_stall_o,
    input  logic          m1_cyc_i,
    input  logic          m1_stb_i,
    input  logic          m1_we_i,
    input  logic [3:0]    m1_sel_i,
    input  logic [AW-1:0] m1_addr_i,
    input  logic [DW-1:0] m1_data_i,
    output logic [DW-1:0] m1_data_o,
    output logic          m1_ack_o,
    output logic          m1_stall_o,
    output logic          cyc_i,
    output logic          stb_i,
    output logic          we_i,
    output logic [3:0]    sel_i,
    output logic [AW-1:0] addr_i,
    output logic [DW-1:0] data_i,
    input  logic [DW-1:0] data_o,
    input  logic          stall_o,
    input  logic          sdram_ack,
    output logic [1:0]    grant,
    output logic          timeout_o
);

    arb_state_t r_state;
    logic [1:0] r_grant;
    logic       r_timeout;
    logic       r_blk1;     // offender held in S_BLOCK is master 1
`ifdef SDRAM_ARB_RR_EN
    logic       r_last1;    // master 1 was granted most recently
`endif

    logic w_own0, w_own1, w_own_cyc, w_blk_cyc, w_oth_cyc, w_pick1, w_wd_exp;

    assign w_own0    = (r_state == S_GNT0);
    assign w_own1    = (r_state == S_GNT1);
    assign w_own_cyc = w_own1 ? m1_cyc_i : m0_cyc_i;
    assign w_blk_cyc = r_blk1 ? m1_cyc_i : m0_cyc_i;
    assign w_oth_cyc = r_blk1 ? m0_cyc_i : m1_cyc_i;

`ifdef SDRAM_ARB_RR_EN
    // On a tie, grant whichever master was not granted last.
    assign w_pick1 = m1_cyc_i && (!m0_cyc_i || !r_last1);
`else
    assign w_pick1 = m1_cyc_i && !m0_cyc_i;
`endif

    // Counter is held clear whenever nobody owns the bus, so every new grant starts at 0.
    arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
        .i_clk     (CLKOUT),
        .i_rst_n   (rst_n),
        .i_clr     (!(w_own0 || w_own1) || sdram_ack),
        .i_en      (w_own0 || w_own1),
        .o_expired (w_wd_exp)
    );

    always_ff @(posedge CLKOUT or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_grant   <= 2'b00;
            r_timeout <= 1'b0;
            r_blk1    <= 1'b0;
`ifdef SDRAM_ARB_RR_EN
            r_last1   <= 1'b1;
`endif
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (m0_cyc_i || m1_cyc_i) begin
                        r_state <= w_pick1 ? S_GNT1 : S_GNT0;
                        r_grant <= w_pick1 ? 2'b10 : 2'b01;
`ifdef SDRAM_ARB_RR_EN
                        r_last1 <= w_pick1;
`endif
                    end
                end
                S_GNT0, S_GNT1: begin
                    // A normal release always passes through S_IDLE, giving the slave one idle cycle.
                    if (!w_own_cyc) begin
                        r_state <= S_IDLE;
                        r_grant <= 2'b00;
                    end else if (w_wd_exp) begin
                        r_state   <= S_BLOCK;
                        r_grant   <= 2'b00;
                        r_timeout <= 1'b1;
                        r_blk1    <= w_own1;
                    end
                end
                S_BLOCK: begin
                    // The non-offending master may take the bus straight away.
                    if (w_oth_cyc) begin
                        r_state <= r_blk1 ? S_GNT0 : S_GNT1;
                        r_grant <= r_blk1 ? 2'b01 : 2'b10;
`ifdef SDRAM_ARB_RR_EN
                        r_last1 <= !r_blk1;
`endif
                    end else if (!w_blk_cyc) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_grant <= 2'b00;
                end
            endcase
        end
    end

    assign grant     = r_grant;
    assign timeout_o = r_timeout;

    // Owner's request path is mirrored to the slave; cyc/stb are cut as soon as the watchdog expires.
    always_comb begin
        cyc_i      = WB_CYC_IDLE;
        stb_i      = WB_STB_IDLE;
        we_i       = WB_WE_IDLE;
        sel_i      = WB_SEL_IDLE;
        addr_i     = '0;
        data_i     = '0;
        m0_data_o  = '0;
        m0_ack_o   = WB_ACK_IDLE;
        m0_stall_o = WB_STALL_IDLE;
        m1_data_o  = '0;
        m1_ack_o   = WB_ACK_IDLE;
        m1_stall_o = WB_STALL_IDLE;
        if (w_own0) begin
            cyc_i      = m0_cyc_i && !w_wd_exp;
            stb_i      = m0_stb_i && !w_wd_exp;
            we_i       = m0_we_i;
            sel_i      = m0_sel_i;
            addr_i     = m0_addr_i;
            data_i     = m0_data_i;
            m0_data_o  = data_o;
            m0_ack_o   = sdram_ack;
            m0_stall_o = stall_o;
        end else if (w_own1) begin
            cyc_i      = m1_cyc_i && !w_wd_exp;
            stb_i      = m1_stb_i && !w_wd_exp;
            we_i       = m1_we_i;
            sel_i      = m1_sel_i;
            addr_i     = m1_addr_i;
            data_i     = m1_data_i;
            m1_data_o  = data_o;
            m1_ack_o   = sdram_ack;
            m1_stall_o = stall_o;
        end
    end

endmodule

// File: tb/tb_sdram_wb_arbiter.sv
// Self-checking bench for sdram_wb_arbiter (TIMEOUT = 8).
// Reference model: a "last granted" variable with the tie-break rule, and a
// word memory written from the bench's own data compared against read-backs
// served by a slave memory that captures what the DUT presents on data_i.
module tb_sdram_wb_arbiter;

    localparam int TO = 8;
    localparam int AW = 32;
    localparam int DW = 32;
`ifdef SDRAM_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic          CLKOUT = 1'b0;
    logic          rst_n;
    logic          m0_cyc_i, m0_stb_i, m0_we_i;
    logic [3:0]    m0_sel_i;
    logic [AW-1:0] m0_addr_i;
    logic [DW-1:0] m0_data_i, m0_data_o;
    logic          m0_ack_o, m0_stall_o;
    logic          m1_cyc_i, m1_stb_i, m1_we_i;
    logic [3:0]    m1_sel_i;
    logic [AW-1:0] m1_addr_i;
    logic [DW-1:0] m1_data_i, m1_data_o;
    logic          m1_ack_o, m1_stall_o;
    logic          cyc_i, stb_i, we_i;
    logic [3:0]    sel_i;
    logic [AW-1:0] addr_i;
    logic [DW-1:0] data_i, data_o;
    logic          stall_o, sdram_ack;
    logic [1:0]    grant;
    logic          timeout_o;

    int nvec = 0;
    int nmis = 0;
    int last_gnt;
    logic [31:0] ref_mem [16];
    logic [31:0] slv_mem [16];
    logic [3:0]  wr_q [$];

    sdram_wb_arbiter #(.TIMEOUT(TO), .AW(AW), .DW(DW)) dut (
        .CLKOUT(CLKOUT), .rst_n(rst_n),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
        .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i), .m0_data_o(m0_data_o),
        .m0_ack_o(m0_ack_o), .m0_stall_o(m0_stall_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
        .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i), .m1_data_o(m1_data_o),
        .m1_ack_o(m1_ack_o), .m1_stall_o(m1_stall_o),
        .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i), .sel_i(sel_i), .addr_i(addr_i),
        .data_i(data_i), .data_o(data_o), .stall_o(stall_o), .sdram_ack(sdram_ack),
        .grant(grant), .timeout_o(timeout_o)
    );

    always #5 CLKOUT = ~CLKOUT;

    initial begin
        #100000;
        $display("FAIL sim_timeout: observed no finish, expected finish before 100000");
        $fatal(1, "simulation stuck");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLKOUT);
        #1;
    endtask

    task automatic drv(input int m, input logic c, input logic s, input logic w,
                       input logic [3:0] sl, input logic [31:0] a, input logic [31:0] d);
        if (m == 0) begin
            m0_cyc_i = c; m0_stb_i = s; m0_we_i = w; m0_sel_i = sl; m0_addr_i = a; m0_data_i = d;
        end else begin
            m1_cyc_i = c; m1_stb_i = s; m1_we_i = w; m1_sel_i = sl; m1_addr_i = a; m1_data_i = d;
        end
    endtask

    // Tie-break rule: round-robin grants the master not granted last; otherwise master 0.
    function automatic int tie_winner(input int last);
        return (RR_EN && last == 0) ? 1 : 0;
    endfunction

    // Single write from an idle bus; slave acks after dly cycles.
    task automatic wr(input int m, input logic [31:0] a, input logic [31:0] d, input int dly);
        logic [3:0] sl;
        sl = 4'($urandom_range(1, 15));
        drv(m, 1'b1, 1'b1, 1'b1, sl, a, d);
        #1;
        chk("wr_pre_grant", 32'(grant), 32'd0);
        tick();
        last_gnt = m;
        chk("wr_grant", 32'(grant), 32'(1 << m));
        chk("wr_addr", addr_i, a);
        chk("wr_data", data_i, d);
        chk("wr_sel", 32'(sel_i), 32'(sl));
        chk("wr_we", 32'(we_i), 32'd1);
        chk("wr_other_stall", 32'(m ? m0_stall_o : m1_stall_o), 32'd1);
        stall_o = 1'($urandom_range(0, 1));
        #1;
        chk("wr_stall_mirror", 32'(m ? m1_stall_o : m0_stall_o), 32'(stall_o));
        stall_o = 1'b0;
        repeat (dly) tick();
        sdram_ack = 1'b1;
        #1;
        chk("wr_ack", 32'(m ? m1_ack_o : m0_ack_o), 32'd1);
        chk("wr_other_ack", 32'(m ? m0_ack_o : m1_ack_o), 32'd0);
        slv_mem[a[3:0]] = data_i;
        ref_mem[a[3:0]] = d;
        tick();
        sdram_ack = 1'b0;
        drv(m, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        tick();
        chk("wr_release", 32'(grant), 32'd0);
    endtask

    // Single read from an idle bus; slave returns its stored word after dly cycles.
    task automatic rd(input int m, input logic [31:0] a, input int dly);
        drv(m, 1'b1, 1'b1, 1'b0, 4'hF, a, 32'h0);
        tick();
        last_gnt = m;
        chk("rd_grant", 32'(grant), 32'(1 << m));
        chk("rd_addr", addr_i, a);
        chk("rd_we", 32'(we_i), 32'd0);
        repeat (dly) tick();
        data_o    = slv_mem[a[3:0]];
        sdram_ack = 1'b1;
        #1;
        chk("rd_data", m ? m1_data_o : m0_data_o, ref_mem[a[3:0]]);
        chk("rd_other_data", m ? m0_data_o : m1_data_o, 32'h0);
        tick();
        sdram_ack = 1'b0;
        data_o    = '0;
        drv(m, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        tick();
        chk("rd_release", 32'(grant), 32'd0);
    endtask

    initial begin
        logic [31:0] a, d;
        int w;

        // Reset state
        rst_n = 1'b0;
        drv(0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drv(1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        data_o = 32'hA5A5_A5A5; stall_o = 1'b0; sdram_ack = 1'b1;
        last_gnt = 1;
        #12;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_timeout", 32'(timeout_o), 32'd0);
        chk("rst_cyc", 32'(cyc_i), 32'd0);
        chk("rst_m0_stall", 32'(m0_stall_o), 32'd1);
        chk("rst_m1_stall", 32'(m1_stall_o), 32'd1);
        chk("rst_m0_ack", 32'(m0_ack_o), 32'd0);
        chk("rst_m0_data", m0_data_o, 32'h0);
        chk("rst_m1_data", m1_data_o, 32'h0);
        data_o = '0; sdram_ack = 1'b0;
        rst_n = 1'b1;
        tick();

        // m0 alone writes 0xDEADBEEF to address 5, ack after 4 cycles
        wr(0, 32'd5, 32'hDEAD_BEEF, 4);

        // Randomized writes and read-backs from either master
        for (int i = 0; i < 8; i++) begin
            a = 32'($urandom_range(0, 15));
            d = $urandom;
            wr(int'($urandom_range(0, 1)), a, d, int'($urandom_range(0, 5)));
            wr_q.push_back(a[3:0]);
        end
        while (wr_q.size() > 0) begin
            rd(int'($urandom_range(0, 1)), 32'(wr_q.pop_front()), int'($urandom_range(0, 5)));
        end

        // Simultaneous requests, three rounds, one idle cycle between grants
        for (int r = 0; r < 3; r++) begin
            drv(0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            drv(1, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            tick();
            w = tie_winner(last_gnt);
            last_gnt = w;
            chk("tie_grant", 32'(grant), 32'(1 << w));
            drv(0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            drv(1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            tick();
            chk("tie_idle", 32'(grant), 32'd0);
        end

        // m1 reads address 7 while m0 requests mid-cycle
        drv(1, 1'b1, 1'b1, 1'b0, 4'hF, 32'd7, 32'h0);
        tick();
        chk("mid_m1_grant", 32'(grant), 32'b10);
        drv(0, 1'b1, 1'b1, 1'b1, 4'hF, 32'd3, 32'h1111_2222);
        tick();
        chk("mid_m1_hold", 32'(grant), 32'b10);
        chk("mid_m0_stall", 32'(m0_stall_o), 32'd1);
        data_o = 32'h1234_5678; sdram_ack = 1'b1;
        #1;
        chk("mid_m1_data", m1_data_o, 32'h1234_5678);
        chk("mid_m0_ack", 32'(m0_ack_o), 32'd0);
        tick();
        data_o = '0; sdram_ack = 1'b0;
        drv(1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        tick();
        chk("mid_idle", 32'(grant), 32'd0);
        tick();
        chk("mid_m0_grant", 32'(grant), 32'b01);
        chk("mid_m0_addr", addr_i, 32'd3);
        drv(0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        tick();

        // Watchdog: m0 holds cyc, slave never acks
        drv(0, 1'b1, 1'b1, 1'b0, 4'hF, 32'd9, 32'h0);
        tick();
        chk("wd_grant", 32'(grant), 32'b01);
        for (int k = 1; k <= TO; k++) begin
            tick();
            if (k < TO) begin
                chk("wd_quiet", 32'(timeout_o), 32'd0);
            end else begin
                chk("wd_pulse", 32'(timeout_o), 32'd1);
                chk("wd_cyc_low", 32'(cyc_i), 32'd0);
                chk("wd_grant_drop", 32'(grant), 32'd0);
                chk("wd_m0_stall", 32'(m0_stall_o), 32'd1);
            end
        end
        tick();
        chk("wd_pulse_end", 32'(timeout_o), 32'd0);
        chk("wd_no_regrant", 32'(grant), 32'd0);
        drv(1, 1'b1, 1'b1, 1'b0, 4'hF, 32'd2, 32'h0);
        tick();
        last_gnt = 1;
        chk("wd_m1_grant", 32'(grant), 32'b10);
        chk("wd_m1_cyc", 32'(cyc_i), 32'd1);
        drv(0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drv(1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        tick();
        chk("wd_idle", 32'(grant), 32'd0);
        drv(0, 1'b1, 1'b1, 1'b0, 4'hF, 32'd9, 32'h0);
        tick();
        last_gnt = 0;
        chk("wd_m0_regrant", 32'(grant), 32'b01);
        drv(0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        tick();

        // Asynchronous reset in the middle of a write
        drv(0, 1'b1, 1'b1, 1'b1, 4'hF, 32'd9, 32'h5555_AAAA);
        tick();
        chk("ar_grant", 32'(grant), 32'b01);
        sdram_ack = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        last_gnt = 1;
        chk("ar_cyc", 32'(cyc_i), 32'd0);
        chk("ar_grant_clr", 32'(grant), 32'd0);
        chk("ar_ack", 32'(m0_ack_o), 32'd0);
        sdram_ack = 1'b0;
        #1;
        rst_n = 1'b1;
        #1;
        chk("ar_still_idle", 32'(grant), 32'd0);
        tick();
        last_gnt = 0;
        chk("ar_regrant", 32'(grant), 32'b01);
        drv(0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        tick();
        chk("ar_release", 32'(grant), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
